// File: rtl/axis_frame_gen_pkg.sv
// Shared constants for the AXI4-Stream frame generator: FSM encoding,
// payload pattern codes and the PRBS31 (x^31 + x^28 + 1) definition.
package axis_frame_gen_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   typedef logic [1:0] pat_t;
   localparam pat_t PAT_INC  = 2'd0;
   localparam pat_t PAT_SEQ  = 2'd1;
   localparam pat_t PAT_PRBS = 2'd2;
   localparam pat_t PAT_RSVD = 2'd3;

   // State bit j holds the bit generated j+1 steps ago, so the taps pick
   // b[k-31] and b[k-28] for the recurrence b[k] = b[k-31] ^ b[k-28].
   localparam logic [30:0] PRBS_SEED  = 31'h7FFF_FFFF;
   localparam int          PRBS_TAP_A = 30;
   localparam int          PRBS_TAP_B = 27;

   function automatic pat_t pat_norm(input pat_t sel);
      return (sel == PAT_RSVD) ? PAT_INC : sel;
   endfunction

endpackage

// File: rtl/axis_prbs_gen.sv
// Parallel PRBS31 source: bits_o is the next DATA_WIDTH sequence bits
// (bit 0 first), taken from the seed when load_i is high.
module axis_prbs_gen
   import axis_frame_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic                  en_i,
   output logic [DATA_WIDTH-1:0] bits_o
);

   logic [30:0] state_q;
   logic [30:0] state_d;

   always_comb begin
      logic [30:0] lfsr;
      lfsr   = load_i ? PRBS_SEED : state_q;
      bits_o = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         bits_o[i] = lfsr[PRBS_TAP_A] ^ lfsr[PRBS_TAP_B];
         lfsr      = {lfsr[29:0], bits_o[i]};
      end
      state_d = lfsr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PRBS_SEED;
      end else if (load_i || en_i) begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/axis_frame_gen.sv
// Programmable AXI4-Stream frame source: frames of configurable length,
// count, gap and payload pattern, with busy/done/frames_sent status.
module axis_frame_gen
   import axis_frame_gen_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int LEN_WIDTH   = 16,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   input  logic                   start,
   input  logic                   stop,
   input  logic [LEN_WIDTH-1:0]   frame_len,
   input  logic [COUNT_WIDTH-1:0] frame_count,
   input  logic [7:0]             gap_cycles,
   input  logic [1:0]             pattern_sel,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] frames_sent
);

   localparam int KW_LOG = $clog2(KEEP_WIDTH);
   localparam int OFF_W  = LEN_WIDTH + KW_LOG + 1;

   logic [1:0]             state_q, state_d;
   logic                   busy_q, busy_d, done_q, done_d, stop_q, stop_d;
   logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
   logic [KEEP_WIDTH-1:0]  tkeep_q, tkeep_d;
   logic [COUNT_WIDTH-1:0] fs_q, fs_d, count_q, count_d;
   logic [LEN_WIDTH-1:0]   beat_q, beat_d, len_q, len_d;
   logic [7:0]             gap_q, gap_d, gap_cnt_q, gap_cnt_d;
   pat_t                   mode_q, mode_d;

   logic                   hs, start_ok, load_beat;
   logic [COUNT_WIDTH-1:0] fs_inc;
   logic [DATA_WIDTH-1:0]  prbs_bits;

   // Next-beat builder: the beat that will be presented after this edge.
   logic [LEN_WIDTH-1:0]   bld_beat, bld_len;
   pat_t                   bld_mode;
   logic [COUNT_WIDTH-1:0] bld_seq;
   logic [31:0]            seq32;
   logic [DATA_WIDTH-1:0]  bld_data;
   logic [KEEP_WIDTH-1:0]  bld_keep;
   logic                   bld_last;

   assign hs     = tvalid_q & m_axis_tready;
   assign fs_inc = fs_q + COUNT_WIDTH'(1);

   axis_prbs_gen #(.DATA_WIDTH(DATA_WIDTH)) u_prbs (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (start_ok),
      .en_i   (hs),
      .bits_o (prbs_bits)
   );

   always_comb begin
      bld_beat = '0;
      bld_len  = len_q;
      bld_mode = mode_q;
      bld_seq  = fs_q;
      if (state_q == ST_IDLE) begin
         bld_len  = frame_len;
         bld_mode = pat_norm(pattern_sel);
         bld_seq  = '0;
      end else if (tlast_q) begin
         bld_seq  = fs_inc;
      end else begin
         bld_beat = beat_q + LEN_WIDTH'(1);
      end
   end

   assign seq32    = 32'(bld_seq);
   assign bld_last = ((OFF_W'(bld_beat) + OFF_W'(1)) << KW_LOG) >= OFF_W'(bld_len);

   for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
      logic [OFF_W-1:0] off;
      logic [7:0]       pat;
      logic             lane_en;
      assign off     = (OFF_W'(bld_beat) << KW_LOG) + OFF_W'(gi);
      assign lane_en = off < OFF_W'(bld_len);
      always_comb begin
         case (bld_mode)
            PAT_PRBS: pat = prbs_bits[gi*8 +: 8];
            PAT_SEQ:  pat = (off < OFF_W'(4)) ? seq32[{off[1:0], 3'b000} +: 8] : off[7:0];
            default:  pat = off[7:0];
         endcase
      end
      assign bld_keep[gi]        = lane_en;
      assign bld_data[gi*8 +: 8] = lane_en ? pat : 8'h00;
   end

   always_comb begin
      state_d   = state_q;   busy_d  = busy_q;  done_d   = 1'b0;
      stop_d    = stop_q;    fs_d    = fs_q;    beat_d   = beat_q;
      gap_cnt_d = gap_cnt_q; tvalid_d = tvalid_q; tlast_d = tlast_q;
      tdata_d   = tdata_q;   tkeep_d = tkeep_q;
      len_d     = len_q;     count_d = count_q; gap_d    = gap_q;  mode_d = mode_q;
      start_ok  = 1'b0;      load_beat = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && frame_len != '0) begin
               start_ok  = 1'b1;
               state_d   = ST_DATA;
               busy_d    = 1'b1;
               stop_d    = 1'b0;
               fs_d      = '0;
               beat_d    = '0;
               len_d     = frame_len;
               count_d   = frame_count;
               gap_d     = gap_cycles;
               mode_d    = pat_norm(pattern_sel);
               tvalid_d  = 1'b1;
               load_beat = 1'b1;
            end
         end
         ST_DATA: begin
            stop_d = stop_q | stop;
            if (hs) begin
               if (!tlast_q) begin
                  beat_d    = beat_q + LEN_WIDTH'(1);
                  load_beat = 1'b1;
               end else begin
                  fs_d   = fs_inc;
                  beat_d = '0;
                  if ((count_q != '0 && fs_inc == count_q) || stop_q || stop) begin
                     state_d  = ST_IDLE;
                     busy_d   = 1'b0;
                     done_d   = 1'b1;
                     tvalid_d = 1'b0;
                     tlast_d  = 1'b0;
                  end else begin
                     // The next frame's first beat is staged now and held while tvalid is low.
                     load_beat = 1'b1;
                     if (gap_q != 8'd0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                        tvalid_d  = 1'b0;
                     end
                  end
               end
            end
         end
         ST_GAP: begin
            if (stop) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (gap_cnt_q == 8'd1) begin
               state_d  = ST_DATA;
               tvalid_d = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load_beat) begin
         tdata_d = bld_data;
         tkeep_d = bld_keep;
         tlast_d = bld_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE; busy_q <= 1'b0; done_q <= 1'b0; stop_q <= 1'b0;
         fs_q <= '0; beat_q <= '0; gap_cnt_q <= '0;
         tvalid_q <= 1'b0; tlast_q <= 1'b0; tdata_q <= '0; tkeep_q <= '0;
         len_q <= '0; count_q <= '0; gap_q <= '0; mode_q <= PAT_INC;
      end else begin
         state_q <= state_d; busy_q <= busy_d; done_q <= done_d; stop_q <= stop_d;
         fs_q <= fs_d; beat_q <= beat_d; gap_cnt_q <= gap_cnt_d;
         tvalid_q <= tvalid_d; tlast_q <= tlast_d; tdata_q <= tdata_d; tkeep_q <= tkeep_d;
         len_q <= len_d; count_q <= count_d; gap_q <= gap_d; mode_q <= mode_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign frames_sent   = fs_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen with a frame-level reference model
// and a per-cycle compare process.
module tb_axis_frame_gen;

   localparam int DW = 64;
   localparam int KW = 8;
   localparam int LW = 16;
   localparam int CW = 32;
   localparam int PRBS_N = 31 + DW * 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] tdata;
   logic [KW-1:0] tkeep;
   logic          tvalid, tlast;
   logic          tready = 1'b1;
   logic          start = 1'b0, stop = 1'b0;
   logic [LW-1:0] frame_len = '0;
   logic [CW-1:0] frame_count = '0;
   logic [7:0]    gap_cycles = '0;
   logic [1:0]    pattern_sel = '0;
   logic          busy, done;
   logic [CW-1:0] frames_sent;

   int   vec = 0;
   int   errs = 0;
   logic rand_ready = 1'b0;
   logic ready_level = 1'b1;

   always #5 clk = ~clk;

   axis_frame_gen #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW), .COUNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .m_axis_tdata  (tdata),
      .m_axis_tkeep  (tkeep),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .m_axis_tlast  (tlast),
      .start         (start),
      .stop          (stop),
      .frame_len     (frame_len),
      .frame_count   (frame_count),
      .gap_cycles    (gap_cycles),
      .pattern_sel   (pattern_sel),
      .busy          (busy),
      .done          (done),
      .frames_sent   (frames_sent)
   );

   // PRBS31 reference: the sequence bit by bit from the recurrence.
   bit prbs_bits [0:PRBS_N-1];
   initial begin
      for (int k = 0; k < PRBS_N; k++)
         prbs_bits[k] = (k < 31) ? 1'b1 : (prbs_bits[k-31] ^ prbs_bits[k-28]);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_beat(input int beat, input int len, input int mode, input logic [31:0] seq,
                             input int gbeat, output logic [63:0] d, output logic [7:0] k, output logic l);
      d = '0;
      k = '0;
      for (int j = 0; j < KW; j++) begin
         int off;
         int idx;
         logic [7:0] b;
         off = beat * KW + j;
         if (off < len) begin
            k[j] = 1'b1;
            if (mode == 2) begin
               for (int t = 0; t < 8; t++) begin
                  idx = 31 + gbeat * DW + 8 * j + t;
                  b[t] = (idx < PRBS_N) ? prbs_bits[idx] : 1'b0;
               end
            end else if (mode == 1 && off < 4) begin
               b = seq[8*off +: 8];
            end else begin
               b = off[7:0];
            end
            d[8*j +: 8] = b;
         end
      end
      l = ((beat + 1) * KW >= len);
   endtask

   // Reference model state and compare process.
   logic          m_busy = 0, m_done = 0, m_stop = 0, m_first = 0, m_track = 0, pend = 0;
   logic [CW-1:0] m_fs = '0, m_count = '0;
   int            m_len = 0, m_mode = 0, m_gap = 0, m_beat = 0, m_gbeat = 0, m_gaplen = 0;
   logic [63:0]   h_data;
   logic [7:0]    h_keep;
   logic          h_last;

   always @(negedge clk) begin
      logic [63:0] ed;
      logic [7:0]  ek;
      logic        el, busy_before, fin;
      if (!rst_n) begin
         chk("rst_tvalid", tvalid, 0);
         chk("rst_tlast", tlast, 0);
         chk("rst_tdata", tdata, 0);
         chk("rst_tkeep", tkeep, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_frames_sent", frames_sent, 0);
         m_busy = 0; m_done = 0; m_stop = 0; m_first = 0; m_track = 0; pend = 0; m_fs = '0;
      end else begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("frames_sent", frames_sent, m_fs);
         if (m_first) begin
            chk("first_valid", tvalid, 1);
            m_first = 0;
         end else if (!m_busy) begin
            chk("idle_valid", tvalid, 0);
         end
         if (pend) begin
            chk("valid_held", tvalid, 1);
            chk("data_held", tdata, h_data);
            chk("keep_held", tkeep, h_keep);
            chk("last_held", tlast, h_last);
         end
         if (m_track) begin
            if (tvalid) begin
               chk("gap_len", m_gaplen, m_gap);
               m_track = 0;
            end else begin
               m_gaplen++;
            end
         end
         busy_before = m_busy;
         m_done = 0;
         pend = 0;
         if (tvalid && tready) begin
            model_beat(m_beat, m_len, m_mode, m_fs, m_gbeat, ed, ek, el);
            chk("tdata", tdata, ed);
            chk("tkeep", tkeep, ek);
            chk("tlast", tlast, el);
            m_gbeat++;
            if (el) begin
               m_fs++;
               m_beat = 0;
               fin = (m_count != 0 && m_fs == m_count) || m_stop || stop;
               if (fin) begin
                  m_busy = 0;
                  m_done = 1;
               end else begin
                  m_track = 1;
                  m_gaplen = 0;
               end
            end else begin
               m_beat++;
            end
         end else if (tvalid) begin
            pend = 1;
            h_data = tdata;
            h_keep = tkeep;
            h_last = tlast;
         end
         if (busy_before && m_busy && stop) begin
            if (m_track && !tvalid) begin
               m_busy = 0;
               m_done = 1;
               m_track = 0;
            end else begin
               m_stop = 1;
            end
         end
         if (start && !busy_before && frame_len != 0) begin
            m_busy = 1; m_first = 1; m_stop = 0; m_track = 0;
            m_fs = '0; m_beat = 0; m_gbeat = 0;
            m_len = frame_len;
            m_count = frame_count;
            m_gap = gap_cycles;
            m_mode = (pattern_sel == 2'd3) ? 0 : pattern_sel;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_start(input int len, input int cnt, input int gap, input int mode);
      frame_len = LW'(len);
      frame_count = CW'(cnt);
      gap_cycles = 8'(gap);
      pattern_sel = 2'(mode);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < budget);
      chk(name, done, 1);
   endtask

   task automatic wait_fs(input string name, input logic [CW-1:0] target, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frames_sent != target && n < budget);
      chk(name, frames_sent, target);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // 1: 20-byte frames x2, no gap, incrementing bytes; config changed after start
      run_start(20, 2, 0, 0);
      frame_len = 16'd5;
      pattern_sel = 2'd1;
      @(negedge clk);
      chk("t1_beat0_data", tdata, 64'h0706050403020100);
      @(negedge clk);
      @(negedge clk);
      chk("t1_beat2_data", tdata, 64'h0000000013121110);
      chk("t1_beat2_keep", tkeep, 8'h0F);
      chk("t1_beat2_last", tlast, 1);
      wait_done("t1_done", 50);
      chk("t1_frames", frames_sent, 2);

      // 2: same shape, sequence header, random backpressure
      tick();
      rand_ready = 1'b1;
      run_start(20, 2, 0, 1);
      @(negedge clk);
      chk("t2_f0_hdr", tdata, 64'h0706050400000000);
      wait_fs("t2_fs1", 1, 200);
      chk("t2_f1_valid", tvalid, 1);
      chk("t2_f1_hdr", tdata, 64'h0706050400000001);
      wait_done("t2_done", 200);
      chk("t2_frames", frames_sent, 2);
      rand_ready = 1'b0;
      ready_level = 1'b1;

      // 3: single-beat frames with a 3-cycle gap, reserved pattern code
      tick();
      tick();
      run_start(8, 3, 3, 3);
      @(negedge clk);
      chk("t3_keep", tkeep, 8'hFF);
      chk("t3_last", tlast, 1);
      chk("t3_data", tdata, 64'h0706050403020100);
      wait_done("t3_done", 100);
      chk("t3_frames", frames_sent, 3);

      // 4: unlimited PRBS run ended by stop mid-frame; a start while busy is ignored
      tick();
      run_start(64, 0, 0, 2);
      @(negedge clk);
      chk("t4_prbs_first", tdata, 64'h3F00000070000000);
      wait_fs("t4_fs1", 1, 100);
      tick();
      tick();
      stop = 1'b1;
      frame_len = 16'd8;
      pattern_sel = 2'd0;
      start = 1'b1;
      tick();
      stop = 1'b0;
      start = 1'b0;
      wait_done("t4_done", 100);
      chk("t4_frames", frames_sent, 2);
      repeat (10) tick();
      chk("t4_idle_valid", tvalid, 0);

      // 5: zero-length start is rejected
      run_start(0, 1, 0, 0);
      repeat (5) tick();
      chk("t5_busy", busy, 0);
      chk("t5_frames", frames_sent, 2);

      // 6: asynchronous reset mid-frame under backpressure, then a fresh PRBS run
      run_start(16, 0, 0, 0);
      wait_fs("t6_fs3", 3, 100);
      ready_level = 1'b0;
      tick();
      tick();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_tvalid", tvalid, 0);
      chk("t6_async_busy", busy, 0);
      chk("t6_async_frames", frames_sent, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      ready_level = 1'b1;
      tick();
      tick();
      run_start(24, 1, 0, 2);
      @(negedge clk);
      chk("t6_prbs_first", tdata, 64'h3F00000070000000);
      wait_done("t6_done", 50);
      chk("t6_frames", frames_sent, 1);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
